// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and types for the DDS host command decoder.
//   - Frame header byte and the six register-write command codes.
//   - Status bytes returned to the host for every parsed or aborted frame.
//   - Parser FSM state enum and control-register field widths.
package dds_pkg;

    localparam logic [7:0] HDR          = 8'hA5;

    localparam logic [7:0] CMD_CH1_WAVE  = 8'h01;
    localparam logic [7:0] CMD_CH1_FREQ  = 8'h02;
    localparam logic [7:0] CMD_CH1_PHASE = 8'h03;
    localparam logic [7:0] CMD_CH2_WAVE  = 8'h11;
    localparam logic [7:0] CMD_CH2_FREQ  = 8'h12;
    localparam logic [7:0] CMD_CH2_PHASE = 8'h13;

    localparam logic [7:0] STAT_OK       = 8'h5A;
    localparam logic [7:0] STAT_BAD_CHK  = 8'hE1;
    localparam logic [7:0] STAT_BAD_CMD  = 8'hE2;
    localparam logic [7:0] STAT_TIMEOUT  = 8'hE3;

    localparam int unsigned WAVE_W  = 4;
    localparam int unsigned FREQ_W  = 25;
    localparam int unsigned PHASE_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StChk,
        StExec
    } state_e;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_CH1_WAVE)  || (cmd == CMD_CH1_FREQ) || (cmd == CMD_CH1_PHASE) ||
               (cmd == CMD_CH2_WAVE)  || (cmd == CMD_CH2_FREQ) || (cmd == CMD_CH2_PHASE);
    endfunction

endpackage

// File: rtl/dds_status_slot.sv
// dds_status_slot: one-entry status register feeding the UART transmitter.
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   load_i            load load_data_i into the slot (overwrites a pending byte)
//   load_data_i       status byte to load
//   tx_ready_i        transmitter accepts the byte when tx_valid_o && tx_ready_i
//   tx_data_o         held status byte
//   tx_valid_o        status pending
module dds_status_slot (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    // A load wins over a same-cycle handshake: the new byte stays pending.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/dds_cmd_decoder.sv
// dds_cmd_decoder: parses 7-byte host frames (A5 CMD D3 D2 D1 D0 CHK) from the UART
// receiver and writes the per-channel DDS control registers.
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   rx_data, rx_valid         received byte strobe (no backpressure)
//   tx_data, tx_valid, tx_ready  status byte to the UART transmitter
//   chN_wave_select/freq_ctrl/phase_ctrl  control registers for channels 1 and 2
//   cfg_update                one-cycle pulse on any register write
//   frame_err                 one-cycle pulse on checksum error, unknown command or timeout
module dds_cmd_decoder
    import dds_pkg::*;
#(
    parameter int unsigned        TIMEOUT_CYCLES = 50_000,
    parameter logic [FREQ_W-1:0]  RST_FREQ       = 25'd1000,
    parameter logic [WAVE_W-1:0]  RST_WAVE       = 4'b0001
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [WAVE_W-1:0]  ch1_wave_select,
    output logic [WAVE_W-1:0]  ch2_wave_select,
    output logic [FREQ_W-1:0]  ch1_freq_ctrl,
    output logic [FREQ_W-1:0]  ch2_freq_ctrl,
    output logic [PHASE_W-1:0] ch1_phase_ctrl,
    output logic [PHASE_W-1:0] ch2_phase_ctrl,
    output logic               cfg_update,
    output logic               frame_err
);

    localparam int unsigned   ToW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    // Only the low FREQ_W payload bits can reach any register, so only those are kept.
    logic [FREQ_W-1:0]    payload_q, payload_d;
    logic [7:0]           xor_q, xor_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic                 chk_ok_q, chk_ok_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;

    logic [WAVE_W-1:0]    ch1_wave_q, ch1_wave_d, ch2_wave_q, ch2_wave_d;
    logic [FREQ_W-1:0]    ch1_freq_q, ch1_freq_d, ch2_freq_q, ch2_freq_d;
    logic [PHASE_W-1:0]   ch1_phase_q, ch1_phase_d, ch2_phase_q, ch2_phase_d;
    logic                 cfg_update_q, cfg_update_d;
    logic                 frame_err_q, frame_err_d;

    logic                 in_frame;
    logic                 timeout;
    logic                 status_load;
    logic [7:0]           status_byte;

    assign in_frame = (state_q == StCmd) || (state_q == StData) || (state_q == StChk);
    assign timeout  = in_frame && !rx_valid && (to_cnt_q == ToLast);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        payload_d    = payload_q;
        xor_d        = xor_q;
        byte_cnt_d   = byte_cnt_q;
        chk_ok_d     = chk_ok_q;
        ch1_wave_d   = ch1_wave_q;
        ch2_wave_d   = ch2_wave_q;
        ch1_freq_d   = ch1_freq_q;
        ch2_freq_d   = ch2_freq_q;
        ch1_phase_d  = ch1_phase_q;
        ch2_phase_d  = ch2_phase_q;
        cfg_update_d = 1'b0;
        frame_err_d  = 1'b0;
        status_load  = 1'b0;
        status_byte  = STAT_OK;

        // Idle gap counter: runs only inside a frame, cleared by every received byte.
        to_cnt_d = (in_frame && !rx_valid && !timeout) ? to_cnt_q + ToW'(1) : '0;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && rx_data == HDR) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (rx_valid) begin
                    cmd_d      = rx_data;
                    xor_d      = rx_data;
                    byte_cnt_d = 2'd0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (rx_valid) begin
                    payload_d  = {payload_q[FREQ_W-9:0], rx_data};
                    xor_d      = xor_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (rx_valid) begin
                    chk_ok_d = (rx_data == xor_q);
                    state_d  = StExec;
                end
            end
            StExec: begin
                // Bytes arriving here are dropped; the UART cannot deliver that fast.
                state_d     = StIdle;
                status_load = 1'b1;
                if (!chk_ok_q) begin
                    frame_err_d = 1'b1;
                    status_byte = STAT_BAD_CHK;
                end else if (!cmd_known(cmd_q)) begin
                    frame_err_d = 1'b1;
                    status_byte = STAT_BAD_CMD;
                end else begin
                    cfg_update_d = 1'b1;
                    status_byte  = STAT_OK;
                    case (cmd_q)
                        CMD_CH1_WAVE:  ch1_wave_d  = payload_q[WAVE_W-1:0];
                        CMD_CH1_FREQ:  ch1_freq_d  = payload_q;
                        CMD_CH1_PHASE: ch1_phase_d = payload_q[PHASE_W-1:0];
                        CMD_CH2_WAVE:  ch2_wave_d  = payload_q[WAVE_W-1:0];
                        CMD_CH2_FREQ:  ch2_freq_d  = payload_q;
                        CMD_CH2_PHASE: ch2_phase_d = payload_q[PHASE_W-1:0];
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout only fires with no byte this cycle, so no case branch above has acted.
        if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            status_load = 1'b1;
            status_byte = STAT_TIMEOUT;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            cmd_q        <= 8'h00;
            payload_q    <= '0;
            xor_q        <= 8'h00;
            byte_cnt_q   <= 2'd0;
            chk_ok_q     <= 1'b0;
            to_cnt_q     <= '0;
            ch1_wave_q   <= RST_WAVE;
            ch2_wave_q   <= RST_WAVE;
            ch1_freq_q   <= RST_FREQ;
            ch2_freq_q   <= RST_FREQ;
            ch1_phase_q  <= '0;
            ch2_phase_q  <= '0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            payload_q    <= payload_d;
            xor_q        <= xor_d;
            byte_cnt_q   <= byte_cnt_d;
            chk_ok_q     <= chk_ok_d;
            to_cnt_q     <= to_cnt_d;
            ch1_wave_q   <= ch1_wave_d;
            ch2_wave_q   <= ch2_wave_d;
            ch1_freq_q   <= ch1_freq_d;
            ch2_freq_q   <= ch2_freq_d;
            ch1_phase_q  <= ch1_phase_d;
            ch2_phase_q  <= ch2_phase_d;
            cfg_update_q <= cfg_update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    dds_status_slot u_status_slot (
        .clk_i       (sys_clk),
        .rst_ni      (sys_rst_n),
        .load_i      (status_load),
        .load_data_i (status_byte),
        .tx_ready_i  (tx_ready),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid)
    );

    assign ch1_wave_select = ch1_wave_q;
    assign ch2_wave_select = ch2_wave_q;
    assign ch1_freq_ctrl   = ch1_freq_q;
    assign ch2_freq_ctrl   = ch2_freq_q;
    assign ch1_phase_ctrl  = ch1_phase_q;
    assign ch2_phase_ctrl  = ch2_phase_q;
    assign cfg_update      = cfg_update_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// tb_dds_cmd_decoder: directed and randomized frames against a frame-level reference model.
module tb_dds_cmd_decoder;

    localparam int unsigned TO = 200;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  ch1_wave_select, ch2_wave_select;
    logic [24:0] ch1_freq_ctrl, ch2_freq_ctrl;
    logic [9:0]  ch1_phase_ctrl, ch2_phase_ctrl;
    logic        cfg_update;
    logic        frame_err;

    always #5 sys_clk = ~sys_clk;

    dds_cmd_decoder #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .ch1_wave_select (ch1_wave_select),
        .ch2_wave_select (ch2_wave_select),
        .ch1_freq_ctrl   (ch1_freq_ctrl),
        .ch2_freq_ctrl   (ch2_freq_ctrl),
        .ch1_phase_ctrl  (ch1_phase_ctrl),
        .ch2_phase_ctrl  (ch2_phase_ctrl),
        .cfg_update      (cfg_update),
        .frame_err       (frame_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: register file and status slot as seen by the host.
    logic [3:0]  m_wave[2];
    logic [24:0] m_freq[2];
    logic [9:0]  m_phase[2];
    logic        m_pend;
    logic [7:0]  m_stat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_wave[c]  = 4'b0001;
            m_freq[c]  = 25'd1000;
            m_phase[c] = 10'd0;
        end
        m_pend = 1'b0;
        m_stat = 8'h00;
    endtask

    // Applies one complete frame to the model and returns the status byte.
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] pl, input logic [7:0] chk,
                               output logic [7:0] st);
        logic [7:0] sum;
        sum = cmd ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
        st  = 8'h5A;
        if (chk != sum) begin
            st = 8'hE1;
        end else begin
            case (cmd)
                8'h01: m_wave[0]  = pl[3:0];
                8'h02: m_freq[0]  = pl[24:0];
                8'h03: m_phase[0] = pl[9:0];
                8'h11: m_wave[1]  = pl[3:0];
                8'h12: m_freq[1]  = pl[24:0];
                8'h13: m_phase[1] = pl[9:0];
                default: st = 8'hE2;
            endcase
        end
        m_pend = 1'b1;
        m_stat = st;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".w1"}, 32'(ch1_wave_select), 32'(m_wave[0]));
        check_eq({tag, ".w2"}, 32'(ch2_wave_select), 32'(m_wave[1]));
        check_eq({tag, ".f1"}, 32'(ch1_freq_ctrl),   32'(m_freq[0]));
        check_eq({tag, ".f2"}, 32'(ch2_freq_ctrl),   32'(m_freq[1]));
        check_eq({tag, ".p1"}, 32'(ch1_phase_ctrl),  32'(m_phase[0]));
        check_eq({tag, ".p2"}, 32'(ch2_phase_ctrl),  32'(m_phase[1]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_regs(tag);
        check_eq({tag, ".txv"}, 32'(tx_valid),   32'd0);
        check_eq({tag, ".txd"}, 32'(tx_data),    32'd0);
        check_eq({tag, ".cfg"}, 32'(cfg_update), 32'd0);
        check_eq({tag, ".err"}, 32'(frame_err),  32'd0);
    endtask

    // One rx strobe spanning exactly one rising edge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] pl,
                             input logic [7:0] chk, input int max_gap);
        logic [7:0] fr[7];
        logic [7:0] st;
        fr[0] = 8'hA5; fr[1] = cmd;
        fr[2] = pl[31:24]; fr[3] = pl[23:16]; fr[4] = pl[15:8]; fr[5] = pl[7:0];
        fr[6] = chk;
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge sys_clk);
            send_byte(fr[i]);
        end
        // One cycle after the CHK strobe: nothing visible yet.
        check_eq({tag, ".cfg_early"}, 32'(cfg_update), 32'd0);
        check_eq({tag, ".txv_early"}, 32'(tx_valid), 32'(m_pend));
        check_regs({tag, ".early"});
        model_frame(cmd, pl, chk, st);
        @(negedge sys_clk);
        check_regs(tag);
        check_eq({tag, ".cfg"}, 32'(cfg_update), 32'(st == 8'h5A));
        check_eq({tag, ".err"}, 32'(frame_err),  32'(st != 8'h5A));
        check_eq({tag, ".txv"}, 32'(tx_valid),   32'd1);
        check_eq({tag, ".txd"}, 32'(tx_data),    32'(st));
        @(negedge sys_clk);
        check_eq({tag, ".cfg_pulse"}, 32'(cfg_update), 32'd0);
        check_eq({tag, ".err_pulse"}, 32'(frame_err),  32'd0);
    endtask

    task automatic handshake(input string tag);
        tx_ready = 1'b1;
        @(negedge sys_clk);
        tx_ready = 1'b0;
        m_pend   = 1'b0;
        check_eq({tag, ".txv"}, 32'(tx_valid), 32'd0);
    endtask

    logic [7:0] known[6];

    initial begin
        logic [7:0]  cmd, chk, g;
        logic [31:0] pl;

        known[0] = 8'h01; known[1] = 8'h02; known[2] = 8'h03;
        known[3] = 8'h11; known[4] = 8'h12; known[5] = 8'h13;

        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        tx_ready  = 1'b0;
        sys_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        run_frame("freq1", 8'h02, 32'h0012_3456, 8'h72, 0);
        check_eq("freq1.abs", 32'(ch1_freq_ctrl), 32'h0012_3456);
        handshake("hs1");

        run_frame("trunc", 8'h13, 32'hFFFF_FFFF, 8'h13, 0);
        check_eq("trunc.abs", 32'(ch2_phase_ctrl), 32'h3FF);

        run_frame("badchk", 8'h01, 32'h0000_0009, 8'h09, 1);
        check_eq("badchk.abs", 32'(tx_data), 32'hE1);
        run_frame("badcmd", 8'h07, 32'h0000_0000, 8'h07, 1);
        check_eq("badcmd.abs", 32'(tx_data), 32'hE2);
        handshake("hs2");

        // Timeout: counter clears on the last byte, terminal value after TO-1 idle cycles,
        // frame_err visible the cycle after that.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        for (int j = 1; j < TO; j++) begin
            @(negedge sys_clk);
            check_eq("to.quiet", 32'(frame_err), 32'd0);
        end
        @(negedge sys_clk);
        m_pend = 1'b1;
        m_stat = 8'hE3;
        check_eq("to.err", 32'(frame_err), 32'd1);
        check_eq("to.txv", 32'(tx_valid),  32'd1);
        check_eq("to.txd", 32'(tx_data),   32'hE3);
        check_regs("to");
        @(negedge sys_clk);
        check_eq("to.err_pulse", 32'(frame_err), 32'd0);
        run_frame("after_to", 8'h11, 32'h0000_0005, 8'h14, 2);

        // Backpressure: two good frames with no accept, then one accept cycle.
        run_frame("bp1", 8'h03, 32'h0000_0155, 8'h03 ^ 8'h01 ^ 8'h55, 1);
        run_frame("bp2", 8'h12, 32'h01AB_CDEF, 8'h12 ^ 8'h01 ^ 8'hAB ^ 8'hCD ^ 8'hEF, 1);
        check_eq("bp.txv", 32'(tx_valid), 32'd1);
        handshake("bp.hs");

        // Reset mid-frame, asserted away from any clock edge.
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h00);
        #2 sys_rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midrst");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        send_byte(8'h33);
        check_eq("stray.txv", 32'(tx_valid), 32'd0);
        run_frame("postrst", 8'h12, 32'h0000_0ABC, 8'h12 ^ 8'h0A ^ 8'hBC, 1);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            if ($urandom_range(0, 7) < 6) cmd = known[$urandom_range(0, 5)];
            else cmd = 8'($urandom_range(0, 255));
            pl  = $urandom;
            chk = cmd ^ pl[31:24] ^ pl[23:16] ^ pl[15:8] ^ pl[7:0];
            if ($urandom_range(0, 4) == 0) chk = chk ^ (8'h01 << $urandom_range(0, 7));
            run_frame("rnd", cmd, pl, chk, 3);
            if ($urandom_range(0, 1) == 1) handshake("rnd.hs");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
